// File: rtl/exp2lin.sv
// exp2lin: inverts the 7-bit lin->exp curve with a 7-step successive-approximation search.
// Optional feature macro: EXP2LIN_NEAREST_EN (adds a NEAR state that rounds to the closer index).
module exp2lin #(
   parameter int unsigned IN_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [IN_W-1:0] target,
   output logic            busy,
   output logic            done,
   output logic [6:0]      lin_out,
   output logic            clamp_hi,
   output logic            clamp_lo
);

   typedef enum logic [2:0] {StIdle, StSearch, StFix, StNear, StDone} state_t;

   state_t          state_q, state_d;
   logic [IN_W-1:0] tgt_q;
   logic [6:0]      acc_q, r_q, lin_q;
   logic [2:0]      bit_q;
   logic            chi_q, clo_q, hi_q, lo_q, done_q;

   logic [6:0]      trial;
   logic [15:0]     f_trial;
   logic            f_gt;

   // Piecewise-linear curve; every product is a sum/difference of shifted copies of n.
   function automatic logic [15:0] curve(input logic [6:0] n);
      logic [15:0] x;
      logic [15:0] y;
      x = {9'd0, n};
      if (n < 7'd8)       y = 16'd7540 - ((x << 8) + (x << 6) + (x << 5) + (x << 3) + (x << 2));
      else if (n < 7'd16) y = 16'd6637 - ((x << 8) - (x << 4) - (x << 2) - x);
      else if (n < 7'd24) y = 16'd5317 - ((x << 7) + (x << 4) + (x << 1) + x);
      else if (n < 7'd32) y = 16'd4006 - ((x << 6) + (x << 4) + (x << 3) + (x << 1));
      else if (n < 7'd40) y = 16'd2983 - ((x << 6) - (x << 3) + x);
      else if (n < 7'd52) y = 16'd2008 - (x << 5);
      else if (n < 7'd74) y = 16'd1039 - ((x << 3) + (x << 2) + x);
      else                y = (16'd52940 - ((x << 8) + (x << 7) + (x << 4) + (x << 3) + x)) >> 8;
      return y;
   endfunction

   // Search trial value and its compare against the full-width target.
   always_comb begin
      trial   = acc_q | (7'd1 << bit_q);
      f_trial = curve(trial);
      f_gt    = IN_W'(f_trial) > tgt_q;
   end

`ifdef EXP2LIN_NEAREST_EN
   logic [IN_W-1:0] d_lo, d_hi;
   // Distances to the neighbours on either side of the target.
   always_comb begin
      d_lo = IN_W'(curve(r_q - 7'd1)) - tgt_q;
      d_hi = tgt_q - IN_W'(curve(r_q));
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StSearch;
         StSearch: if (bit_q == 3'd0) state_d = StFix;
`ifdef EXP2LIN_NEAREST_EN
         StFix:    state_d = StNear;
`else
         StFix:    state_d = StDone;
`endif
         StNear:   state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath: latch, search, fix-up and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q  <= '0;
         acc_q  <= '0;
         r_q    <= '0;
         bit_q  <= '0;
         chi_q  <= 1'b0;
         clo_q  <= 1'b0;
         lin_q  <= '0;
         hi_q   <= 1'b0;
         lo_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  tgt_q <= target;
                  acc_q <= '0;
                  bit_q <= 3'd6;
               end
            end
            StSearch: begin
               if (f_gt) acc_q <= trial;
               bit_q <= bit_q - 3'd1;
            end
            StFix: begin
               // acc holds the largest n with f(n) > target, unless none exists.
               if (tgt_q >= IN_W'(7540))  r_q <= 7'd0;
               else if (acc_q == 7'd127)  r_q <= 7'd127;
               else                       r_q <= acc_q + 7'd1;
               chi_q <= tgt_q > IN_W'(7540);
               clo_q <= tgt_q < IN_W'(3);
            end
            StNear: begin
`ifdef EXP2LIN_NEAREST_EN
               if (!chi_q && !clo_q && r_q != 7'd0 && d_lo < d_hi) r_q <= r_q - 7'd1;
`endif
            end
            StDone: begin
               lin_q  <= r_q;
               hi_q   <= chi_q;
               lo_q   <= clo_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign lin_out  = lin_q;
   assign clamp_hi = hi_q;
   assign clamp_lo = lo_q;

endmodule
